// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit.
//   - funct3 encodings of the RV32 conditional branches
//   - 2-bit saturating counter encodings and sat_inc/sat_dec helpers
//   - BTB/BHT entry layout (tag/target fields sized for PCs up to PC_W bits,
//     narrower tags are stored zero-extended)
package branch_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        logic [1:0]      ctr;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: maps funct3 and the ALU flags to a taken
// condition, and flags the two unused funct3 codes as illegal.
//   funct3 in  3  branch funct3
//   zero   in  1  ALU zero flag
//   lt     in  1  ALU signed less-than
//   ltu    in  1  ALU unsigned less-than
//   cond   out 1  branch condition (0 for illegal funct3)
//   legal  out 1  funct3 is a defined branch
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond,
    output logic       legal
);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
// IF side: direct-mapped BTB + 2-bit BHT give a zero-latency taken/target
// prediction. EX side: resolves branches/jumps combinationally, raises
// flush/redirect on mispredict, and updates tables and statistics at the edge.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   lookup_pc                   IF-stage PC
//   pred_taken, pred_target     prediction for lookup_pc (combinational)
//   res_valid, res_jump         resolving control transfer, JAL/JALR flag
//   res_pc, res_target          PC and computed taken target
//   res_funct3, res_zero,
//   res_lt, res_ltu             branch type and ALU flags
//   res_pred_taken,
//   res_pred_target             prediction that travelled with the instruction
//   actual_taken, flush,
//   redirect_pc                 resolution outputs (combinational)
//   stat_branches,
//   stat_mispredicts            saturating statistics counters
// XLEN must not exceed branch_pkg::PC_W.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              res_valid,
    input  logic              res_jump,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [XLEN-1:0]   res_target,
    input  logic [2:0]        res_funct3,
    input  logic              res_zero,
    input  logic              res_lt,
    input  logic              res_ltu,
    input  logic              res_pred_taken,
    input  logic [XLEN-1:0]   res_pred_target,
    output logic              actual_taken,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    entry_t table_q [ENTRIES];

    // Lookup path: reads current (pre-update) contents.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx      = lookup_pc[IDX_W+1:2];
    assign lk_tag      = lookup_pc[XLEN-1:IDX_W+2];
    assign lk_hit      = table_q[lk_idx].valid && (table_q[lk_idx].tag == PC_W'(lk_tag));
    assign pred_taken  = lk_hit & table_q[lk_idx].ctr[1];
    assign pred_target = pred_taken ? XLEN'(table_q[lk_idx].target) : lookup_pc + XLEN'(4);

    // Resolution path.
    logic cond;
    logic cond_legal;
    logic res_legal;
    logic taken;

    branch_cond_eval u_cond (
        .funct3 (res_funct3),
        .zero   (res_zero),
        .lt     (res_lt),
        .ltu    (res_ltu),
        .cond   (cond),
        .legal  (cond_legal)
    );

    // Jumps ignore funct3, so they are always legal.
    assign res_legal    = res_valid & (res_jump | cond_legal);
    assign taken        = res_valid & (res_jump | (cond_legal & cond));
    assign actual_taken = taken;
    assign flush        = res_valid &
                          ((taken != res_pred_taken) | (taken & (res_pred_target != res_target)));
    assign redirect_pc  = !res_valid ? '0 :
                          taken      ? res_target : res_pc + XLEN'(4);

    // Next contents of the entry addressed by res_pc.
    logic [IDX_W-1:0] rs_idx;
    logic [TAG_W-1:0] rs_tag;
    entry_t           rs_ent;
    logic             rs_hit;
    logic             upd_en;
    entry_t           upd_ent;

    assign rs_idx = res_pc[IDX_W+1:2];
    assign rs_tag = res_pc[XLEN-1:IDX_W+2];
    assign rs_ent = table_q[rs_idx];
    assign rs_hit = rs_ent.valid && (rs_ent.tag == PC_W'(rs_tag));

    always_comb begin
        upd_en  = 1'b0;
        upd_ent = rs_ent;
        if (res_legal) begin
            if (rs_hit) begin
                upd_en = 1'b1;
                if (res_jump) begin
                    upd_ent.ctr    = CTR_ST;
                    upd_ent.target = PC_W'(res_target);
                end else if (taken) begin
                    upd_ent.ctr    = sat_inc(rs_ent.ctr);
                    upd_ent.target = PC_W'(res_target);
                end else begin
                    upd_ent.ctr    = sat_dec(rs_ent.ctr);
                end
            end else if (taken) begin
                // Not-taken misses leave the table alone.
                upd_en         = 1'b1;
                upd_ent.valid  = 1'b1;
                upd_ent.tag    = PC_W'(rs_tag);
                upd_ent.target = PC_W'(res_target);
                upd_ent.ctr    = res_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    // Table storage; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= ENTRY_RESET;
            end
        end else if (upd_en) begin
            table_q[rs_idx] <= upd_ent;
        end
    end

    // Saturating statistics; illegal funct3 flushes are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res_legal && (stat_branches != '1)) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (res_legal && flush && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
            end
        end
    end

endmodule
